// File: rtl/llc_input_arbiter_n.sv
// LLC front-end input arbiter: fixed-priority channel select with resume precedence,
// tag/set split and a DEPTH-entry decode FIFO. Define LLC_ARB_STARVE_EN for starvation aging.
module llc_input_arbiter_n #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned SET_W      = 8,
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned CLR_CH     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*ADDR_W-1:0]      ch_addr,
  input  logic [NUM_CH-1:0]             ch_stall,
  output logic [NUM_CH-1:0]             ch_ready,
  input  logic                          resume_valid,
  input  logic [SET_W-1:0]              resume_set,
  input  logic                          stall_active,
  input  logic [ADDR_W-SET_W-1:0]       stall_tag,
  input  logic [SET_W-1:0]              stall_set,
  output logic                          clr_stall,
  output logic                          out_valid,
  output logic                          out_resume,
  output logic [NUM_CH-1:0]             out_ch,
  output logic [ADDR_W-SET_W-1:0]       out_tag,
  output logic [SET_W-1:0]              out_set,
  input  logic                          out_pop,
  output logic                          full,
  output logic [$clog2(DEPTH+1)-1:0]    usage,
  output logic                          idle
);

  localparam int unsigned TAG_W = ADDR_W - SET_W;
  localparam int unsigned USE_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (STARVE_MAX < 1 || DEPTH < 1 || CLR_CH >= NUM_CH) begin : g_bad_cfg
    $error("llc_input_arbiter_n: invalid parameter set");
  end

  logic [USE_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic              idle_q, idle_d;
  logic              mem_res_q [DEPTH];
  logic [NUM_CH-1:0] mem_ch_q  [DEPTH];
  logic [TAG_W-1:0]  mem_tag_q [DEPTH];
  logic [SET_W-1:0]  mem_set_q [DEPTH];

  logic [NUM_CH-1:0] elig, starved, cand, grant;
  logic [ADDR_W-1:0] gnt_addr;
  logic              push_ok, push, pop, found;

  assign elig    = ch_valid & ~ch_stall;
  assign push_ok = (cnt_q != USE_W'(DEPTH)) || out_pop;

`ifdef LLC_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] age_q [NUM_CH];

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      starved[i] = elig[i] && (age_q[i] == CNT_W'(STARVE_MAX));
    end
  end

  // Ages also in non-push-capable cycles; any loss of eligibility restarts the count.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rst || !elig[i] || grant[i]) begin
        age_q[i] <= '0;
      end else if (age_q[i] != CNT_W'(STARVE_MAX)) begin
        age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  always_comb begin
    cand     = (|starved) ? starved : elig;
    grant    = '0;
    gnt_addr = '0;
    found    = 1'b0;
    if (push_ok && !resume_valid && !rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cand[i] && !found) begin
          grant[i] = 1'b1;
          gnt_addr = ch_addr[i*ADDR_W +: ADDR_W];
          found    = 1'b1;
        end
      end
    end
  end

  assign ch_ready  = grant;
  assign clr_stall = grant[CLR_CH] && stall_active &&
                     (gnt_addr[ADDR_W-1:SET_W] == stall_tag) &&
                     (gnt_addr[SET_W-1:0] == stall_set);

  assign push = push_ok && !rst && (resume_valid || (|grant));
  assign pop  = out_pop && (cnt_q != '0);

  always_comb begin
    cnt_d  = cnt_q + USE_W'(push) - USE_W'(pop);
    rd_d   = rd_q;
    wr_d   = wr_q;
    if (pop)  rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (push) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    idle_d = (cnt_d == '0) && !resume_valid && !(|elig);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      idle_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      idle_q <= idle_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_res_q[wr_q] <= resume_valid;
      mem_ch_q[wr_q]  <= grant;
      mem_tag_q[wr_q] <= resume_valid ? '0 : gnt_addr[ADDR_W-1:SET_W];
      mem_set_q[wr_q] <= resume_valid ? resume_set : gnt_addr[SET_W-1:0];
    end
  end

  // Head fields are masked when empty so the uninitialised storage never leaks out.
  assign out_valid  = (cnt_q != '0);
  assign out_resume = out_valid && mem_res_q[rd_q];
  assign out_ch     = out_valid ? mem_ch_q[rd_q]  : '0;
  assign out_tag    = out_valid ? mem_tag_q[rd_q] : '0;
  assign out_set    = out_valid ? mem_set_q[rd_q] : '0;
  assign full       = (cnt_q == USE_W'(DEPTH));
  assign usage      = cnt_q;
  assign idle       = idle_q;

endmodule

// File: tb/tb_llc_input_arbiter_n.sv
// Bench for llc_input_arbiter_n: directed scenarios then random traffic, checked against a queue-based model.
module tb_llc_input_arbiter_n;
  localparam int NUM_CH = 4, DEPTH = 2, ADDR_W = 26, SET_W = 8, TAG_W = 18, SMAX = 3, CLR_CH = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_valid, ch_stall, ch_ready, out_ch;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic                     resume_valid, stall_active, clr_stall, out_valid, out_resume, out_pop, full, idle;
  logic [SET_W-1:0]         resume_set, stall_set, out_set;
  logic [TAG_W-1:0]         stall_tag, out_tag;
  logic [1:0]               usage;

  llc_input_arbiter_n #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SET_W(SET_W),
    .STARVE_MAX(SMAX), .CLR_CH(CLR_CH)
  ) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_addr(ch_addr), .ch_stall(ch_stall),
    .ch_ready(ch_ready), .resume_valid(resume_valid), .resume_set(resume_set),
    .stall_active(stall_active), .stall_tag(stall_tag), .stall_set(stall_set),
    .clr_stall(clr_stall), .out_valid(out_valid), .out_resume(out_resume), .out_ch(out_ch),
    .out_tag(out_tag), .out_set(out_set), .out_pop(out_pop), .full(full), .usage(usage), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              res;
    bit [NUM_CH-1:0] ch;
    bit [TAG_W-1:0]  tag;
    bit [SET_W-1:0]  set;
  } ent_t;

  ent_t             q[$];
  int               age[NUM_CH];
  bit               m_idle, m_live, m_fresh;
  logic [ADDR_W-1:0] addr[NUM_CH];
  int               total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int              g;
    bit              pok, exp_clr;
    bit [NUM_CH-1:0] el, exp_rdy;
    ent_t            e;
    for (int i = 0; i < NUM_CH; i++) ch_addr[i*ADDR_W +: ADDR_W] = addr[i];
    @(negedge clk);
    el  = ch_valid & ~ch_stall;
    pok = (q.size() < DEPTH) || out_pop;
    g   = -1;
    if (!rst && pok && !resume_valid) begin
`ifdef LLC_ARB_STARVE_EN
      for (int i = 0; i < NUM_CH; i++) if (g < 0 && el[i] && age[i] == SMAX) g = i;
`endif
      for (int i = 0; i < NUM_CH; i++) if (g < 0 && el[i]) g = i;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    exp_clr = (g == CLR_CH) && stall_active && (addr[CLR_CH][ADDR_W-1:SET_W] == stall_tag) &&
              (addr[CLR_CH][SET_W-1:0] == stall_set);
    chk("ch_ready", ch_ready, exp_rdy);
    chk("clr_stall", clr_stall, exp_clr);
    if (m_live) begin
      chk("usage", usage, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("out_valid", out_valid, q.size() != 0);
      chk("idle", idle, m_idle);
      if (q.size() != 0) begin
        chk("out_resume", out_resume, q[0].res);
        chk("out_ch", out_ch, q[0].ch);
        chk("out_tag", out_tag, q[0].tag);
        chk("out_set", out_set, q[0].set);
      end else if (m_fresh) begin
        chk("rst_resume", out_resume, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_set", out_set, 0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      for (int i = 0; i < NUM_CH; i++) age[i] = 0;
      m_idle = 1; m_live = 1; m_fresh = 1;
    end else begin
      if (out_pop && q.size() != 0) void'(q.pop_front());
      if (pok && resume_valid) begin
        e.res = 1; e.ch = '0; e.tag = '0; e.set = resume_set;
        q.push_back(e); m_fresh = 0;
      end else if (g >= 0) begin
        e.res = 0; e.ch = '0; e.ch[g] = 1'b1;
        e.tag = addr[g][ADDR_W-1:SET_W]; e.set = addr[g][SET_W-1:0];
        q.push_back(e); m_fresh = 0;
      end
      for (int i = 0; i < NUM_CH; i++)
        age[i] = (!el[i] || g == i) ? 0 : ((age[i] < SMAX) ? age[i] + 1 : SMAX);
      m_idle = (q.size() == 0) && !resume_valid && (el == 0);
    end
  endtask

  task automatic new_addrs();
    for (int i = 0; i < NUM_CH; i++) addr[i] = ADDR_W'({$urandom, $urandom});
  endtask

  initial begin
    m_live = 0; m_fresh = 0; m_idle = 1;
    for (int i = 0; i < NUM_CH; i++) age[i] = 0;
    new_addrs();
    rst = 1; ch_valid = '0; ch_stall = '0; resume_valid = 0; resume_set = '0;
    stall_active = 0; stall_tag = '0; stall_set = '0; out_pop = 0;
    step(); step();
    rst = 0;

    // reset with a full FIFO
    ch_valid = 4'b0001; step(); step();
    ch_valid = '0; rst = 1; step();
    rst = 0; step();

    // priority
    new_addrs(); out_pop = 1; ch_valid = 4'b1010; step(); step();
    ch_valid = '0; step();

    // resume precedence
    resume_valid = 1; resume_set = 8'hFF; ch_valid = 4'b0001; step();
    resume_valid = 0; ch_valid = '0; step();

    // full and back-pressure
    out_pop = 0; ch_valid = 4'b0001; repeat (3) step();
    out_pop = 1; repeat (2) step();
    ch_valid = '0; repeat (3) step();

    // starvation
    ch_valid = 4'b1001; repeat (9) step();
    ch_valid = '0; step();

    // stall clear, match then one-bit tag miss
    new_addrs(); ch_valid = 4'b0010; stall_active = 1;
    stall_tag = addr[1][ADDR_W-1:SET_W]; stall_set = addr[1][SET_W-1:0]; step();
    stall_tag[0] = ~stall_tag[0]; step();
    stall_active = 0; ch_valid = '0; step();

    repeat (3000) begin
      new_addrs();
      rst          = ($urandom_range(99) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        ch_valid[i] = ($urandom_range(9) < 6);
        ch_stall[i] = ($urandom_range(99) < 15);
      end
      resume_valid = ($urandom_range(99) < 8);
      resume_set   = SET_W'($urandom);
      out_pop      = ($urandom_range(9) < 6);
      stall_active = $urandom_range(1);
      if ($urandom_range(1) == 1) begin
        stall_tag = addr[CLR_CH][ADDR_W-1:SET_W]; stall_set = addr[CLR_CH][SET_W-1:0];
      end else begin
        stall_tag = TAG_W'($urandom); stall_set = SET_W'($urandom);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
